// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, fetch FSM encodings and the NOP constant
package riscv_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of {pc, instr} with clear; head reads 0 when empty
module fetch_buf #(
  parameter int W = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d  = clear ? '0 : wr_q + PW'(push);
    rd_d  = clear ? '0 : rd_q + PW'(pop);
    cnt_d = clear ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign count = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign dout  = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with tagged buffer and flush
module instr_fetch_unit import riscv_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic          pc_hold,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic push, full;
  assign imem_addr   = pc_in & ~AW'(3);
  assign imem_req    = rst & (state_q == S_REQ) & ~full & ~flush;
  assign pc_hold     = ~(imem_req & imem_gnt);
  assign instr_valid = (count != '0) & ~flush;
  // Responses outside S_WAIT/S_DROP are stale (e.g. from before reset) and dropped
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    case (state_q)
      S_REQ:  if (imem_req & imem_gnt) begin
        req_pc_d = imem_addr;
        state_d  = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) begin
        push    = ~flush;
        state_d = S_REQ;
      end else if (flush) state_d = S_DROP;
      S_DROP: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end
  fetch_buf #(.W(AW + DW), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (instr_valid & instr_ready),
    .clear (flush),
    .din   ({req_pc_q, imem_rdata}),
    .dout  ({instr_pc, instr_out}),
    .count (count),
    .full  (full)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch traffic checked against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic pc_hold, flush, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, instr_out, instr_pc;
  always #5 clk = ~clk;
  instr_fetch_unit #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_hold(pc_hold), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc)
  );
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t q[$];
  logic [31:0] dut_pops[$];
  bit outst = 0, drop = 0;
  logic [31:0] pend_pc = '0, pc_r = '0, resp_addr = '0, flush_tgt = 32'h40;
  bit resp_on = 0;
  int resp_due = 0, cyc = 0, gnt_block = 0;
  int lat_min = 1, lat_max = 1, p_gnt = 100, p_rdy = 100, p_flush = 0;
  bit rst_v = 0;
  task automatic cycle();
    bit exp_req, req_s, hold_s, vld_s;
    logic [31:0] addr_s, pc_s;
    ent_t e;
    @(negedge clk);
    rst = rst_v;
    if (!rst) begin
      q.delete();
      outst = 0;
      drop = 0;
    end
    imem_gnt = ($urandom_range(99) < p_gnt) && (cyc >= gnt_block);
    instr_ready = $urandom_range(99) < p_rdy;
    flush = rst && ($urandom_range(99) < p_flush);
    pc_in = pc_r;
    imem_rvalid = resp_on && (resp_due == cyc);
    imem_rdata = imem_rvalid ? mem_word(resp_addr) : $urandom;
    #1;
    req_s = imem_req; hold_s = pc_hold; addr_s = imem_addr; vld_s = instr_valid; pc_s = instr_pc;
    exp_req = rst && !outst && (q.size() < DEPTH) && !flush;
    check("imem_req", req_s, exp_req);
    if (exp_req) check("imem_addr", addr_s, {pc_r[31:2], 2'b00});
    check("pc_hold", hold_s, !(exp_req && imem_gnt));
    check("instr_valid", vld_s, (q.size() != 0) && !flush);
    if (q.size() != 0) begin
      check("instr_pc", pc_s, q[0].pc);
      check("instr_out", instr_out, q[0].data);
    end
    if (!rst) begin
      check("rst_instr_out", instr_out, 0);
      check("rst_instr_pc", pc_s, 0);
    end
    if (vld_s && instr_ready) dut_pops.push_back(pc_s);
    @(posedge clk);
    if (rst) begin
      if ((q.size() != 0) && !flush && instr_ready) void'(q.pop_front());
      if (outst && !drop && imem_rvalid && !flush) begin
        e.pc = pend_pc;
        e.data = mem_word(pend_pc);
        q.push_back(e);
      end
      if (flush) q.delete();
      if (outst && imem_rvalid) begin
        outst = 0;
        drop = 0;
      end else if (outst && flush) drop = 1;
      if (exp_req && imem_gnt) begin
        outst = 1;
        drop = 0;
        pend_pc = {pc_r[31:2], 2'b00};
      end
    end
    if (imem_rvalid) resp_on = 0;
    if (req_s && imem_gnt) begin
      resp_on = 1;
      resp_due = cyc + $urandom_range(lat_max, lat_min);
      resp_addr = addr_s;
    end
    if (flush) begin
      pc_r = flush_tgt;
      flush_tgt = 32'h40 + 32'($urandom_range(63)) * 4;
    end else if (!hold_s) pc_r = pc_r + 4;
    cyc++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    rst_v = 0;
    run(2);
    rst_v = 1;
    run(16);
    check("p1_pops", dut_pops.size() >= 3, 1);
    if (dut_pops.size() >= 3) begin
      check("p1_pc0", dut_pops[0], 32'h0);
      check("p1_pc1", dut_pops[1], 32'h4);
      check("p1_pc2", dut_pops[2], 32'h8);
    end
    p_rdy = 0;
    run(20);
    check("p2_full_hold", pc_hold, 1);
    check("p2_full_valid", instr_valid, 1);
    p_rdy = 100;
    run(10);
    lat_min = 3; lat_max = 3; p_gnt = 80; p_rdy = 70; p_flush = 10;
    run(300);
    lat_min = 1; lat_max = 4; p_gnt = 70; p_rdy = 60; p_flush = 5;
    run(2000);
    lat_min = 1; lat_max = 1; p_gnt = 100; p_rdy = 100; p_flush = 0;
    run(30);
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 50 && !outst; i++) cycle();
    check("p6_outstanding", outst, 1);
    rst_v = 0;
    run(2);
    rst_v = 1;
    resp_on = 1;
    resp_due = cyc + 1;
    gnt_block = cyc + 2;
    lat_min = 1; lat_max = 2;
    run(40);
    p_rdy = 50; p_flush = 3; p_gnt = 80;
    run(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
